// File: rtl/full_dummy_project_top.sv
// Processing stage: reads entry i of the current page from two input BRAMs,
// adds the two words and writes the sum to the same address in the output BRAM.
module full_dummy_project_top #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_proc,
   input  logic [1:0]        bx_in,
   output logic              bx_out,
   output logic [ADDR_W-1:0] mem1_readaddr,
   output logic              mem1_enb,
   input  logic [DATA_W-1:0] mem1_dout,
   output logic [ADDR_W-1:0] mem2_readaddr,
   output logic              mem2_enb,
   input  logic [DATA_W-1:0] mem2_dout,
   output logic              memout_ena,
   output logic              memout_wea,
   output logic [ADDR_W-1:0] memout_writeaddr,
   output logic [DATA_W-1:0] memout_din
);

   localparam int IDX_W = ADDR_W - 1;

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              page_q, page_d;
   logic              page_sel;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_en_q, rd_en_d;

   logic [RD_LATENCY-1:0] vld_q;
   logic [ADDR_W-1:0]     adr_q [RD_LATENCY];

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              bx_q, bx_d;

   // Only the page bit of the bunch-crossing number matters here.
   logic unused_bx_hi;
   assign unused_bx_hi = bx_in[1];

   // Read issue: the page is latched only at entry 0 so a mid-frame bx change is ignored.
   always_comb begin
      idx_d     = idx_q;
      page_d    = page_q;
      page_sel  = page_q;
      rd_addr_d = rd_addr_q;
      rd_en_d   = 1'b0;
      if (en_proc) begin
         if (idx_q == {IDX_W{1'b0}}) begin
            page_sel = bx_in[0];
         end else begin
            page_sel = page_q;
         end
         page_d    = page_sel;
         rd_addr_d = {page_sel, idx_q};
         rd_en_d   = 1'b1;
         idx_d     = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
         rd_en_d = 1'b0;
      end
   end

   // Write stage: data, address and page hold their last value between writes.
   always_comb begin
      wr_en_d   = vld_q[RD_LATENCY-1];
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      bx_d      = bx_q;
      if (vld_q[RD_LATENCY-1]) begin
         wr_data_d = mem1_dout + mem2_dout;
         wr_addr_d = adr_q[RD_LATENCY-1];
         bx_d      = adr_q[RD_LATENCY-1][ADDR_W-1];
      end else begin
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q     <= {IDX_W{1'b0}};
         page_q    <= 1'b0;
         rd_addr_q <= {ADDR_W{1'b0}};
         rd_en_q   <= 1'b0;
         vld_q     <= {RD_LATENCY{1'b0}};
         for (int i = 0; i < RD_LATENCY; i++) begin
            adr_q[i] <= {ADDR_W{1'b0}};
         end
         wr_en_q   <= 1'b0;
         wr_addr_q <= {ADDR_W{1'b0}};
         wr_data_q <= {DATA_W{1'b0}};
         bx_q      <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         page_q    <= page_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         // Valid bit and address travel alongside the BRAM read pipeline.
         vld_q[0]  <= rd_en_q;
         adr_q[0]  <= rd_addr_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            adr_q[i] <= adr_q[i-1];
         end
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         bx_q      <= bx_d;
      end
   end

   assign mem1_readaddr    = rd_addr_q;
   assign mem2_readaddr    = rd_addr_q;
   assign mem1_enb         = rd_en_q;
   assign mem2_enb         = rd_en_q;
   assign memout_ena       = wr_en_q;
   assign memout_wea       = wr_en_q;
   assign memout_writeaddr = wr_addr_q;
   assign memout_din       = wr_data_q;
   assign bx_out           = bx_q;

endmodule

// File: tb/tb_full_dummy_project_top.sv
// Directed bench with BRAM models; expected writes are queued when reads are issued.
module tb_full_dummy_project_top;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_proc;
   logic [1:0]  bx_in;
   logic        bx_out;
   logic [4:0]  mem1_readaddr, mem2_readaddr, memout_writeaddr;
   logic        mem1_enb, mem2_enb, memout_ena, memout_wea;
   logic [31:0] mem1_dout, mem2_dout, memout_din;

   full_dummy_project_top dut (
      .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in), .bx_out(bx_out),
      .mem1_readaddr(mem1_readaddr), .mem1_enb(mem1_enb), .mem1_dout(mem1_dout),
      .mem2_readaddr(mem2_readaddr), .mem2_enb(mem2_enb), .mem2_dout(mem2_dout),
      .memout_ena(memout_ena), .memout_wea(memout_wea),
      .memout_writeaddr(memout_writeaddr), .memout_din(memout_din)
   );

   always #5 clk = ~clk;

   // Two-stage (registered output) read model of the input BRAMs.
   logic [31:0] m1 [32];
   logic [31:0] m2 [32];
   logic [31:0] m1_r, m2_r;
   always @(posedge clk) begin
      if (mem1_enb) m1_r <= m1[mem1_readaddr];
      if (mem2_enb) m2_r <= m2[mem2_readaddr];
      mem1_dout <= m1_r;
      mem2_dout <= m2_r;
   end

   typedef struct {
      int          due;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];

   int          checks = 0;
   int          passed = 0;
   int          fails  = 0;
   int          cyc    = 0;
   logic [3:0]  m_idx  = 4'd0;
   logic        m_page = 1'b0;
   logic [4:0]  last_addr = 5'd0;
   logic [31:0] last_din  = 32'd0;
   logic        last_bx   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: update the reference model from the sampled inputs, then check outputs.
   task automatic step();
      logic       r_v, en_v, sel;
      logic [1:0] bx_v;
      logic [4:0] a;
      logic [31:0] s;
      exp_t e;
      r_v = reset; en_v = en_proc; bx_v = bx_in;
      @(posedge clk);
      cyc++;
      #1;
      if (r_v) begin
         m_idx = 4'd0; m_page = 1'b0;
         q.delete();
         last_addr = 5'd0; last_din = 32'd0; last_bx = 1'b0;
         chk("rst_enb", {62'd0, mem1_enb, mem2_enb}, 64'd0);
         chk("rst_raddr", {54'd0, mem1_readaddr, mem2_readaddr}, 64'd0);
      end else if (en_v) begin
         sel = (m_idx == 4'd0) ? bx_v[0] : m_page;
         m_page = sel;
         a = {sel, m_idx};
         s = m1[a] + m2[a];
         e.due = cyc + 3; e.addr = a; e.data = s;
         q.push_back(e);
         m_idx = m_idx + 4'd1;
         chk("enb", {62'd0, mem1_enb, mem2_enb}, 64'd3);
         chk("raddr1", {59'd0, mem1_readaddr}, {59'd0, a});
         chk("raddr2", {59'd0, mem2_readaddr}, {59'd0, a});
      end else begin
         chk("enb_idle", {62'd0, mem1_enb, mem2_enb}, 64'd0);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("wea", {62'd0, memout_wea, memout_ena}, 64'd3);
         chk("waddr", {59'd0, memout_writeaddr}, {59'd0, e.addr});
         chk("din", {32'd0, memout_din}, {32'd0, e.data});
         chk("bx_out", {63'd0, bx_out}, {63'd0, e.addr[4]});
         last_addr = e.addr; last_din = e.data; last_bx = e.addr[4];
      end else begin
         chk("no_wea", {62'd0, memout_wea, memout_ena}, 64'd0);
         chk("hold_waddr", {59'd0, memout_writeaddr}, {59'd0, last_addr});
         chk("hold_din", {32'd0, memout_din}, {32'd0, last_din});
         chk("hold_bx", {63'd0, bx_out}, {63'd0, last_bx});
      end
   endtask

   initial begin
      reset = 1'b1; en_proc = 1'b0; bx_in = 2'd0;
      for (int i = 0; i < 32; i++) begin m1[i] = 32'd5; m2[i] = 32'd7; end
      repeat (4) step();
      reset = 1'b0;
      repeat (3) step();

      // Constant data, page 0, then page 1, then back to page 0.
      en_proc = 1'b1; bx_in = 2'd2;
      repeat (16) step();
      bx_in = 2'd3;
      repeat (16) step();
      bx_in = 2'd0;
      repeat (8) step();
      bx_in = 2'd1;          // mid-frame change must not move the page
      repeat (8) step();
      repeat (16) step();    // this frame picks page 1
      en_proc = 1'b0;
      repeat (4) step();

      // Distinct data with a 4-cycle pause after idx 5.
      for (int i = 0; i < 32; i++) begin
         m1[i] = 32'(i * 3 + 1);
         m2[i] = 32'(i * 1000 + 17);
      end
      en_proc = 1'b1; bx_in = 2'd0;
      repeat (6) step();
      en_proc = 1'b0;
      repeat (4) step();
      en_proc = 1'b1;
      repeat (10) step();
      en_proc = 1'b0;
      repeat (4) step();

      // Carry out of the top bit is dropped.
      for (int i = 0; i < 32; i++) begin m1[i] = 32'hFFFF_FFFF; m2[i] = 32'h0000_0002; end
      en_proc = 1'b1; bx_in = 2'd1;
      repeat (16) step();
      en_proc = 1'b0;
      repeat (4) step();

      // Reset after idx 8 has been issued: in-flight reads are dropped.
      for (int i = 0; i < 32; i++) begin
         m1[i] = 32'(i + 100);
         m2[i] = 32'(i * 7);
      end
      en_proc = 1'b1; bx_in = 2'd1;
      repeat (9) step();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0; bx_in = 2'd0;
      repeat (16) step();
      en_proc = 1'b0;
      repeat (5) step();

      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
